// File: rtl/wallace_mac_accum_pkg.sv
// Shared types and constants for the Wallace-tree multiply-accumulate block.
package wallace_mac_accum_pkg;

  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  localparam int WT_LEVELS = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/wallace_mac_accum_wallace.sv
// Combinational 16x16 unsigned Wallace-tree multiplier: 3:2 carry-save
// reduction of the partial products followed by one final carry-propagate add.
module wallace_16bit
  import wallace_mac_accum_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_prod
);

  // Rows live in fixed slots; unused slots are zero, so every level can run the
  // same 5 compressors plus a pass-through of slot 15 (16->11->8->6->4->3->2).
  function automatic logic [PROD_W-1:0] wallace_mul(input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
    logic [PROD_W-1:0] rows [OP_W];
    logic [PROD_W-1:0] nxt  [OP_W];
    logic [PROD_W-1:0] maj;
    for (int i = 0; i < OP_W; i++) begin
      rows[i] = {{(PROD_W-OP_W){1'b0}}, (a & {OP_W{b[i]}})} << i;
      nxt[i]  = {PROD_W{1'b0}};
    end
    for (int l = 0; l < WT_LEVELS; l++) begin
      for (int g = 0; g < 5; g++) begin
        maj = (rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
              (rows[3*g+1] & rows[3*g+2]);
        nxt[2*g]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
        nxt[2*g+1] = {maj[PROD_W-2:0], 1'b0};
      end
      nxt[10] = rows[15];
      for (int k = 11; k < OP_W; k++) begin
        nxt[k] = {PROD_W{1'b0}};
      end
      rows = nxt;
    end
    return rows[0] + rows[1];
  endfunction

  assign o_prod = wallace_mul(i_a, i_b);

endmodule

// File: rtl/wallace_mac_accum.sv
// Three-stage multiply-accumulate: operand register, Wallace product register,
// then a frame accumulator feeding a one-entry result register with backpressure.
module wallace_mac_accum
  import wallace_mac_accum_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic              w_stall;
  logic              r_s1_valid, r_s1_last;
  logic [OP_W-1:0]   r_s1_a, r_s1_b;
  logic              r_s2_valid, r_s2_last;
  logic [PROD_W-1:0] r_s2_prod;
  logic [PROD_W-1:0] w_prod;
  acc_state_e        r_acc_state, w_acc_state_nxt;
  out_state_e        r_out_state, w_out_state_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt, w_count_upd;
  logic              r_ovf, w_ovf_nxt, w_ovf_upd;
  logic [ACC_W:0]    w_sum;
  logic              w_beat, w_load;
  logic [ACC_W-1:0]  r_out_acc;
  logic [CNT_W-1:0]  r_out_count;
  logic              r_out_ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Two-flop release of the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_stall   = (r_out_state == FULL) && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = (r_out_state == FULL);
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  wallace_16bit u_mul (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_prod (w_prod)
  );

  // Operand and product pipeline stages; everything freezes under stall.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= {OP_W{1'b0}};
      r_s1_b     <= {OP_W{1'b0}};
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= {PROD_W{1'b0}};
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_last <= in_last;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= w_prod;
    end
  end

  assign w_beat      = !w_stall && r_s2_valid;
  assign w_load      = w_beat && r_s2_last;
  // The carry out of the widened add is the overflow of this beat.
  assign w_sum       = ((r_acc_state == ACCUM) ? {1'b0, r_acc} : {(ACC_W+1){1'b0}}) +
                       {{(ACC_W+1-PROD_W){1'b0}}, r_s2_prod};
  assign w_ovf_upd   = ((r_acc_state == ACCUM) && r_ovf) || w_sum[ACC_W];
  assign w_count_upd = (r_acc_state == IDLE) ? CNT_ONE : sat_inc(r_count);

  // Accumulator next state: a last beat publishes and returns to IDLE.
  always_comb begin
    w_acc_state_nxt = r_acc_state;
    w_acc_nxt       = r_acc;
    w_count_nxt     = r_count;
    w_ovf_nxt       = r_ovf;
    case (r_acc_state)
      IDLE, ACCUM: begin
        if (w_beat && r_s2_last) begin
          w_acc_state_nxt = IDLE;
          w_acc_nxt       = {ACC_W{1'b0}};
          w_count_nxt     = {CNT_W{1'b0}};
          w_ovf_nxt       = 1'b0;
        end else if (w_beat) begin
          w_acc_state_nxt = ACCUM;
          w_acc_nxt       = w_sum[ACC_W-1:0];
          w_count_nxt     = w_count_upd;
          w_ovf_nxt       = w_ovf_upd;
        end else begin
          w_acc_state_nxt = r_acc_state;
        end
      end
      default: begin
        w_acc_state_nxt = IDLE;
        w_acc_nxt       = {ACC_W{1'b0}};
        w_count_nxt     = {CNT_W{1'b0}};
        w_ovf_nxt       = 1'b0;
      end
    endcase
  end

  // Result slot next state: a new result may replace one being handed off.
  always_comb begin
    w_out_state_nxt = r_out_state;
    case (r_out_state)
      EMPTY: begin
        if (w_load) w_out_state_nxt = FULL;
        else        w_out_state_nxt = EMPTY;
      end
      FULL: begin
        if (w_load)         w_out_state_nxt = FULL;
        else if (out_ready) w_out_state_nxt = EMPTY;
        else                w_out_state_nxt = FULL;
      end
      default: w_out_state_nxt = EMPTY;
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc_state <= IDLE;
      r_out_state <= EMPTY;
      r_acc       <= {ACC_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
      r_out_acc   <= {ACC_W{1'b0}};
      r_out_count <= {CNT_W{1'b0}};
      r_out_ovf   <= 1'b0;
    end else begin
      r_acc_state <= w_acc_state_nxt;
      r_out_state <= w_out_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      if (w_load) begin
        r_out_acc   <= w_sum[ACC_W-1:0];
        r_out_count <= w_count_upd;
        r_out_ovf   <= w_ovf_upd;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_accum.sv
// Directed bench: two instances (ACC_W=40/CNT_W=16 and ACC_W=32/CNT_W=2) share
// stimulus; frame vectors come from a table, corner cases from short sequences.
module tb_wallace_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        in_last;
  logic        out_ready;

  logic        a_ready, a_valid, a_ovf;
  logic [39:0] a_acc;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_ovf;
  logic [31:0] b_acc;
  logic [1:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [39:0] handoff_q[$];

  always #5 clk = ~clk;

  wallace_mac_accum u_dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(a_valid),
    .out_ready(out_ready), .out_acc(a_acc), .out_count(a_cnt), .out_ovf(a_ovf)
  );

  wallace_mac_accum #(.ACC_W(32), .CNT_W(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(b_valid),
    .out_ready(out_ready), .out_acc(b_acc), .out_count(b_cnt), .out_ovf(b_ovf)
  );

  // Record every result handed off by the 40-bit instance.
  always @(posedge clk) begin
    if (rst_n && a_valid && out_ready) handoff_q.push_back(a_acc);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic [39:0] acc40;
    logic [31:0] acc32;
    logic [15:0] cnt;
    logic        ovf40;
    logic        ovf32;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int t = 0; t < 50 && !done; t++) begin
      if (a_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL send timeout: in_ready stayed 0, expected 1");
    end
  endtask

  // Called right after the last beat was accepted: checks the two-edge latency.
  task automatic check_frame(input string nm, input logic [39:0] e40, input logic [31:0] e32,
                             input logic [15:0] ecnt, input logic eo40, input logic eo32);
    logic [15:0] ecnt_b;
    ecnt_b = (ecnt > 16'd3) ? 16'd3 : ecnt;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_last = 1'b1;
    @(negedge clk);
    chk({nm, " early valid"}, a_valid, 1'b0);
    @(negedge clk);
    chk({nm, " valid40"}, a_valid, 1'b1);
    chk({nm, " valid32"}, b_valid, 1'b1);
    chk({nm, " acc40"}, a_acc, e40);
    chk({nm, " acc32"}, b_acc, e32);
    chk({nm, " cnt40"}, a_cnt, ecnt);
    chk({nm, " cnt32"}, b_cnt, ecnt_b);
    chk({nm, " ovf40"}, a_ovf, eo40);
    chk({nm, " ovf32"}, b_ovf, eo32);
  endtask

  initial begin
    vecs[0]  = '{16'd3,     16'd5,     1'b0, 40'd0,          32'd0,          16'd0, 1'b0, 1'b0};
    vecs[1]  = '{16'd7,     16'd11,    1'b0, 40'd0,          32'd0,          16'd0, 1'b0, 1'b0};
    vecs[2]  = '{16'd65535, 16'd65535, 1'b1, 40'd4294836317, 32'd4294836317, 16'd3, 1'b0, 1'b0};
    vecs[3]  = '{16'd65535, 16'd65535, 1'b0, 40'd0,          32'd0,          16'd0, 1'b0, 1'b0};
    vecs[4]  = '{16'd65535, 16'd65535, 1'b1, 40'd8589672450, 32'd4294705154, 16'd2, 1'b0, 1'b1};
    vecs[5]  = '{16'd2,     16'd2,     1'b1, 40'd4,          32'd4,          16'd1, 1'b0, 1'b0};
    vecs[6]  = '{16'd0,     16'd1234,  1'b1, 40'd0,          32'd0,          16'd1, 1'b0, 1'b0};
    vecs[7]  = '{16'd1,     16'd1,     1'b1, 40'd1,          32'd1,          16'd1, 1'b0, 1'b0};
    vecs[8]  = '{16'd100,   16'd200,   1'b0, 40'd0,          32'd0,          16'd0, 1'b0, 1'b0};
    vecs[9]  = '{16'd300,   16'd400,   1'b1, 40'd140000,     32'd140000,     16'd2, 1'b0, 1'b0};
    vecs[10] = '{16'd12345, 16'd54321, 1'b1, 40'd670592745,  32'd670592745,  16'd1, 1'b0, 1'b0};
    vecs[11] = '{16'd43690, 16'd21845, 1'b1, 40'd954408050,  32'd954408050,  16'd1, 1'b0, 1'b0};
    for (int i = 12; i < 16; i++)
      vecs[i] = '{16'd1, 16'd1, 1'b0, 40'd0, 32'd0, 16'd0, 1'b0, 1'b0};
    vecs[16] = '{16'd1,     16'd1,     1'b1, 40'd5,          32'd5,          16'd5, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset valid40", a_valid, 1'b0);
    chk("reset valid32", b_valid, 1'b0);
    chk("reset acc40", a_acc, 40'd0);
    chk("reset cnt40", a_cnt, 16'd0);
    chk("reset ovf40", a_ovf, 1'b0);
    chk("reset ready40", a_ready, 1'b1);
    chk("reset ready32", b_ready, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].last);
      if (vecs[i].last)
        check_frame($sformatf("vec%0d", i), vecs[i].acc40, vecs[i].acc32, vecs[i].cnt,
                    vecs[i].ovf40, vecs[i].ovf32);
    end

    // Two frames queued behind a held result.
    repeat (2) @(negedge clk);
    handoff_q.delete();
    out_ready = 1'b0;
    send(16'd10, 16'd10, 1'b1);
    send(16'd20, 16'd20, 1'b0);
    send(16'd3,  16'd3,  1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("stall%0d ready", c), a_ready, 1'b0);
      chk($sformatf("stall%0d valid", c), a_valid, 1'b1);
      chk($sformatf("stall%0d acc", c), a_acc, 40'd100);
      chk($sformatf("stall%0d cnt", c), a_cnt, 16'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall handoffs", handoff_q.size(), 3'd2);
    chk("stall first", handoff_q.size() > 0 ? handoff_q[0] : 40'd0, 40'd100);
    chk("stall second", handoff_q.size() > 1 ? handoff_q[1] : 40'd0, 40'd409);

    // Back-to-back single-beat frames.
    handoff_q.delete();
    send(16'd1, 16'd2, 1'b1);
    send(16'd3, 16'd4, 1'b1);
    send(16'd5, 16'd6, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b valid0", a_valid, 1'b1);
    chk("b2b acc0", a_acc, 40'd2);
    @(negedge clk);
    chk("b2b valid1", a_valid, 1'b1);
    chk("b2b acc1", a_acc, 40'd12);
    @(negedge clk);
    chk("b2b valid2", a_valid, 1'b1);
    chk("b2b acc2", a_acc, 40'd30);
    @(negedge clk);
    chk("b2b drained", a_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("b2b handoffs", handoff_q.size(), 3'd3);
    chk("b2b order", handoff_q.size() > 2 ? handoff_q[2] : 40'd0, 40'd30);

    // Reset with a pending result and a partial frame in flight.
    out_ready = 1'b0;
    send(16'd9, 16'd9, 1'b1);
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset valid", a_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset valid", a_valid, 1'b0);
    chk("mid-reset acc", a_acc, 40'd0);
    chk("mid-reset ready", a_ready, 1'b1);
    chk("mid-reset valid32", b_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    send(16'd6, 16'd7, 1'b1);
    check_frame("post-reset", 40'd42, 32'd42, 16'd1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wallace_mac_accum.md
WALLACE_MAC_ACCUM -- requirements
Module: wallace_mac_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator/result width (legal range 32..48).
REQ-002 SHALL have parameter CNT_W, default 16, beat-counter width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset), listed first.
REQ-004 in_valid  in  1  operand beat valid.
REQ-005 in_ready  out  1  block can accept a beat.
REQ-006 in_a  in  16  unsigned multiplicand.
REQ-007 in_b  in  16  unsigned multiplier.
REQ-008 in_last  in  1  final beat of frame.
REQ-009 out_valid  out  1  frame result valid.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 out_acc  out  ACC_W  sum of frame products, modulo 2^ACC_W.
REQ-012 out_count  out  CNT_W  beats in frame, saturating.
REQ-013 out_ovf  out  1  sticky: frame sum exceeded 2^ACC_W-1.

Function
REQ-014 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 Pipeline: S1 registers a, b, last and a valid bit at acceptance; S2 registers the 32-bit product S1.a*S1.b and carries valid/last; S3 accumulates.
REQ-016 stall = out_valid && !out_ready; in_ready = !stall. When stall is high, S1, S2, S3 and all counters SHALL hold.
REQ-017 When not stalled, each stage SHALL advance every cycle; bubbles carry valid=0 and SHALL NOT change the accumulator, count or ovf.
REQ-018 Accumulator FSM states: IDLE (acc=0, count=0, ovf=0) and ACCUM. A valid S2 beat in IDLE SHALL load acc=product and count=1, then enter ACCUM; in ACCUM it SHALL add product to acc and increment count.
REQ-019 Addition SHALL be zero-extended to ACC_W+1 bits; the carry-out SHALL set ovf (sticky per frame); acc keeps the low ACC_W bits.
REQ-020 count SHALL saturate at 2^CNT_W-1.
REQ-021 On a valid S2 beat with last=1, the updated acc/count/ovf SHALL load out_acc/out_count/out_ovf, out_valid SHALL be set, and the FSM SHALL return to IDLE in the same edge.
REQ-022 Latency: a last beat accepted on edge N SHALL produce out_valid=1 after edge N+2 when no stall occurs.
REQ-023 Output FSM states: EMPTY and FULL. FULL->EMPTY on out_ready when no new result is loading. A new result SHALL load while the old one is handed off (out_valid && out_ready) and out_valid SHALL stay 1.
REQ-024 out_acc, out_count and out_ovf SHALL be stable while out_valid && !out_ready.
REQ-025 A single-beat frame (first beat has last=1) SHALL output product, count=1.
REQ-026 in_a, in_b and in_last SHALL be ignored when in_valid=0.

Reset
REQ-027 While rst_n=0, every register SHALL clear: out_valid=0, out_acc=0, out_count=0, out_ovf=0, stage valid bits=0, FSMs at IDLE/EMPTY. in_ready SHALL read 1.
REQ-028 Reset mid-frame SHALL discard the partial frame and any unconsumed result. The first beat after release SHALL start a new frame.
REQ-029 Reset deassertion SHALL be synchronised to clk internally (two-flop release).

Structure
REQ-030 A shared package SHALL hold the accumulator FSM enum (IDLE, ACCUM), the output FSM enum (EMPTY, FULL) and the PROD_W=32 constant.
REQ-031 The product SHALL be computed by one instance of the existing 16-bit Wallace multiplier sub-module, wallace_16bit, placed combinationally between S1 and S2. It SHALL NOT use a behavioural multiply.

Verification
REQ-032 Frame (3,5),(7,11),(65535,65535,last), ACC_W=40 -> out_acc=4294836317, out_count=3, out_ovf=0, out_valid 2 edges after the last beat.
REQ-033 ACC_W=32, frame (65535,65535),(65535,65535,last) -> out_acc=4294705154, out_ovf=1; the next frame (2,2,last) -> out_acc=4, out_ovf=0.
REQ-034 Single beat (0,1234,last) -> out_acc=0, out_count=1. Single beat (1,1,last) -> out_acc=1.
REQ-035 out_ready held low for 10 cycles with two queued frames -> in_ready=0 and outputs stable. On release, both results appear in order with no loss or duplication.
REQ-036 Back-to-back last beats on consecutive cycles with out_ready=1 -> out_valid continuously high; each result handed off exactly once.
REQ-037 Assert rst_n=0 after the 2nd beat of a 4-beat frame, then send (6,7,last) -> out_acc=42, out_count=1.
